// File: rtl/itrx_amba2_ahb_pkg.sv
// Shared AMBA2 AHB types and helpers for the itrx AHB slave family.
package itrx_amba2_ahb_pkg;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_BUSY   = 2'b01,
    TRANS_NONSEQ = 2'b10,
    TRANS_SEQ    = 2'b11
  } te_htrans;

  typedef enum logic {
    HWRITE_READ  = 1'b0,
    HWRITE_WRITE = 1'b1
  } te_hwrite;

  typedef enum logic [2:0] {
    SIZE_BYTE   = 3'd0,
    SIZE_HALF   = 3'd1,
    SIZE_WORD   = 3'd2,
    SIZE_DWORD  = 3'd3,
    SIZE_4WORD  = 3'd4,
    SIZE_8WORD  = 3'd5,
    SIZE_16WORD = 3'd6,
    SIZE_32WORD = 3'd7
  } te_hsize;

  typedef enum logic [1:0] {
    RESP_OKAY  = 2'b00,
    RESP_ERROR = 2'b01,
    RESP_RETRY = 2'b10,
    RESP_SPLIT = 2'b11
  } te_hresp;

  typedef struct packed {
    logic cacheable;
    logic bufferable;
    logic privileged;
    logic data;
  } ts_hprot;

  // Little-endian lane mask for buses up to 64 bits; caller truncates to its lane count.
  // Assumes the access is already size-aligned.
  function automatic logic [7:0] f_hsize_be(input te_hsize hsize, input logic [2:0] addr_lsbs);
    logic [7:0] base;
    case (hsize)
      SIZE_BYTE: base = 8'h01;
      SIZE_HALF: base = 8'h03;
      SIZE_WORD: base = 8'h0F;
      default:   base = 8'hFF;
    endcase
    return base << addr_lsbs;
  endfunction

endpackage

// File: rtl/itrx_amba2_ahb_slv_if.sv
// AHB slave front-end: one back-end req/ack handshake per AHB transfer, with
// wait states, two-cycle ERROR for illegal accesses, back-end errors and timeouts.
//
// state  | meaning
// IDLE   | no transfer in progress, zero-wait OKAY
// ACCESS | back-end request outstanding
// ERR1   | first ERROR cycle (hreadyout low)
// ERR2   | second ERROR cycle (hreadyout high), may accept a new transfer
module itrx_amba2_ahb_slv_if
  import itrx_amba2_ahb_pkg::*;
#(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int TO_CYC = 255
) (
  input  logic            hclk,
  input  logic            hresetn,
  input  logic            hsel,
  input  logic [AW-1:0]   haddr,
  input  te_htrans        htrans,
  input  te_hwrite        hwrite,
  input  te_hsize         hsize,
  input  ts_hprot         hprot,
  input  logic [DW-1:0]   hwdata,
  input  logic            hready,
  output logic            hreadyout,
  output te_hresp         hresp,
  output logic [DW-1:0]   hrdata,
  output logic            be_req,
  output logic            be_we,
  output logic [AW-1:0]   be_addr,
  output logic [DW/8-1:0] be_be,
  output ts_hprot         be_prot,
  output logic [DW-1:0]   be_wdata,
  input  logic            be_ack,
  input  logic            be_err,
  input  logic [DW-1:0]   be_rdata
);

  localparam int BW = DW / 8;
  localparam int LW = $clog2(BW);
  localparam int TW = (TO_CYC > 0) ? $clog2(TO_CYC + 1) : 1;
  localparam logic [TW-1:0] TMAX  = TW'(TO_CYC);
  localparam logic [TW-1:0] TLAST = TW'((TO_CYC > 0) ? TO_CYC - 1 : 0);

  typedef enum logic [1:0] {IDLE, ACCESS, ERR1, ERR2} te_slv_state;

  te_slv_state state, state_nxt, free_nxt;

  logic            sample, misalign, illegal, in_free, load;
  logic            acked_ok, timeout, fail;
  logic [TW-1:0]   timer;
  logic [AW-1:0]   addr_q;
  logic            we_q;
  logic [BW-1:0]   be_q;
  ts_hprot         prot_q;

  assign sample = hsel & hready & ((htrans == TRANS_NONSEQ) | (htrans == TRANS_SEQ));

  always_comb begin
    case (hsize)
      SIZE_BYTE:  misalign = 1'b0;
      SIZE_HALF:  misalign = haddr[0];
      SIZE_WORD:  misalign = |haddr[1:0];
      SIZE_DWORD: misalign = |haddr[2:0];
      default:    misalign = 1'b0;
    endcase
  end

  assign illegal  = (int'(hsize) > LW) | misalign;
  assign acked_ok = be_ack & ~be_err;
  assign timeout  = (TO_CYC != 0) && (timer == TLAST);
  // An ack in the expiry cycle takes priority over the timeout.
  assign fail     = (be_ack & be_err) | (~be_ack & timeout);
  assign in_free  = (state == IDLE) | (state == ERR2) | ((state == ACCESS) & acked_ok);
  assign load     = in_free & sample & ~illegal;

  always_ff @(posedge hclk) begin
    if (!hresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    if (!sample)      free_nxt = IDLE;
    else if (illegal) free_nxt = ERR1;
    else              free_nxt = ACCESS;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, ERR2: state_nxt = free_nxt;
      ACCESS: begin
        if (acked_ok)  state_nxt = free_nxt;
        else if (fail) state_nxt = ERR2;
      end
      ERR1:    state_nxt = ERR2;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    hreadyout = 1'b1;
    hresp     = RESP_OKAY;
    hrdata    = '0;
    be_req    = 1'b0;
    case (state)
      ACCESS: begin
        be_req    = 1'b1;
        hreadyout = acked_ok;
        hresp     = fail ? RESP_ERROR : RESP_OKAY;
        if (be_ack && !we_q) hrdata = be_rdata;
      end
      ERR1: begin
        hreadyout = 1'b0;
        hresp     = RESP_ERROR;
      end
      ERR2:    hresp = RESP_ERROR;
      default: ;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      addr_q <= '0;
      we_q   <= 1'b0;
      be_q   <= '0;
      prot_q <= '0;
      timer  <= '0;
    end else if (load) begin
      addr_q <= haddr & ~AW'(BW - 1);
      we_q   <= (hwrite == HWRITE_WRITE);
      be_q   <= BW'(f_hsize_be(hsize, 3'(haddr[LW-1:0])));
      prot_q <= hprot;
      timer  <= '0;
    end else if (state == ACCESS && timer != TMAX) begin
      timer <= timer + TW'(1);
    end
  end

  assign be_we    = we_q;
  assign be_addr  = addr_q;
  assign be_be    = be_q;
  assign be_prot  = prot_q;
  assign be_wdata = hwdata;

endmodule
